// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage.
//   NOP_INSTR_DEFAULT  - instruction driven when the fetch queue is empty
//   RESET_PC_DEFAULT   - default fetch address after reset
//   IMEM_WORDS/IMEM_AW - instruction memory geometry (512 x 32)
//   IDX_HI/IDX_LO      - byte-PC slice that forms the memory word index
//   fetch_entry_t      - one prefetch queue entry {pc, instr}
//   sat_add            - saturating 32-bit add for the optional perf counters
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam int          IMEM_WORDS        = 512;
    localparam int          IMEM_AW           = 9;
    localparam int          IDX_HI            = 10;
    localparam int          IDX_LO            = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/imem_sync_ram.sv
// imem_sync_ram: 512 x 32 instruction memory, one write port and one
// synchronous read port. On a same-address read/write the read returns the
// old contents (read-first).
//   clk      - clock
//   we       - write enable
//   wr_addr  - write word address
//   wr_din   - write data
//   re       - read enable; rd_data updates on the following edge
//   rd_addr  - read word address
//   rd_data  - registered read data
module imem_sync_ram
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [IMEM_AW-1:0] wr_addr,
    input  logic [31:0]        wr_din,
    input  logic               re,
    input  logic [IMEM_AW-1:0] rd_addr,
    output logic [31:0]        rd_data
);

    logic [31:0] mem_reg [IMEM_WORDS];

    // Array contents are never reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[wr_addr] <= wr_din;
        end
        if (re) begin
            rd_data <= mem_reg[rd_addr];
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage with a prefetch queue.
// Owns the fetch PC, a synchronous instruction memory (loaded through a write
// port) and a DEPTH-entry queue that presents one instruction per cycle to
// decode. A redirect flushes the queue and the in-flight read and restarts
// fetch at the (word-aligned) target.
//   clk, reset          - clock; asynchronous active-high reset
//   we0/wr_addr0/wr_din0- instruction memory loader port
//   redirect/redirect_pc- branch/jump redirect and byte target
//   stall               - decode not ready; head entry held
//   out_valid/instr/pc  - head of queue (NOP_INSTR / 0 when empty)
// Optional build macro IF_FETCH_PERF_EN adds saturating counters
//   perf_fetched (responses pushed), perf_flushed (entries + in-flight read
//   discarded by redirect), perf_stall (cycles with out_valid & stall).
module if_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we0,
    input  logic [IMEM_AW-1:0] wr_addr0,
    input  logic [31:0]        wr_din0,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               stall,
    output logic               out_valid,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
    output logic [31:0]        perf_stall
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_reg;
    logic          inflight_reg;
    logic [31:0]   inflight_pc_reg;
    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    fetch_entry_t  queue_reg [DEPTH];

    logic [31:0]   rd_data;
    logic [CW:0]   occ_total;
    logic          issue;
    logic          push;
    logic          pop;
    fetch_entry_t  head_entry;

    // The low two target bits are ignored by design.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // An outstanding read already owns a queue slot, so it counts toward
    // occupancy when deciding whether another read may be issued.
    assign occ_total = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
    assign issue     = !redirect && (occ_total < DEPTH_OCC);
    assign push      = inflight_reg && !redirect;
    assign pop       = (count_reg != '0) && !stall && !redirect;

    imem_sync_ram u_imem (
        .clk     (clk),
        .we      (we0),
        .wr_addr (wr_addr0),
        .wr_din  (wr_din0),
        .re      (issue),
        .rd_addr (fetch_pc_reg[IDX_HI:IDX_LO]),
        .rd_data (rd_data)
    );

    // Control state: fetch PC, in-flight tracking and queue pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
        end else if (redirect) begin
            fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
            inflight_reg <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= fetch_pc_reg;
                // Full 32-bit increment; the memory index wraps on its own.
                fetch_pc_reg    <= fetch_pc_reg + 32'd4;
            end
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Queue storage: no reset needed, validity is tracked by count_reg.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (tail_reg == PW'(gi))) begin
                queue_reg[gi] <= '{pc: inflight_pc_reg, instr: rd_data};
            end
        end
    end

    assign head_entry = queue_reg[head_reg];
    assign out_valid  = (count_reg != '0);
    assign out_instr  = out_valid ? head_entry.instr : NOP_INSTR;
    assign out_pc     = out_valid ? head_entry.pc    : 32'h0;

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) begin
                perf_fetched <= sat_add(perf_fetched, 32'd1);
            end
            if (redirect) begin
                perf_flushed <= sat_add(perf_flushed, 32'(occ_total));
            end
            if (out_valid && stall) begin
                perf_stall <= sat_add(perf_stall, 32'd1);
            end
        end
    end
`endif

endmodule
